// File: rtl/conv2d_seq_engine.sv
// Sequential 2-D convolution: one multiply-accumulate per cycle, results streamed over valid/ready.
// Latency: N_TAPS MAC cycles plus one OUT cycle per output element; DONE pulse after the final handshake.
// Backpressure: OUT holds out_data/out_index stable while out_ready=0; optional ReLU via CONV2D_SEQ_RELU_EN.
module conv2d_seq_engine #(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = 8,
    parameter int ACC_WIDTH    = 48,
    parameter int BATCH_SIZE   = 1,
    parameter int IN_CHANNELS  = 8,
    parameter int OUT_CHANNELS = 32,
    parameter int IN_HEIGHT    = 7,
    parameter int IN_WIDTH     = 7,
    parameter int KERNEL_SIZE  = 7,
    parameter int STRIDE       = 1,
    parameter int PADDING      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]     input_tensor_flat,
    input  logic [OUT_CHANNELS*IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights_flat,
    input  logic [OUT_CHANNELS*DATA_WIDTH-1:0] bias_flat,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [31:0]           out_index,
    output logic                  done
);

    localparam int OUT_HEIGHT = (IN_HEIGHT + 2*PADDING - KERNEL_SIZE) / STRIDE + 1;
    localparam int OUT_WIDTH  = (IN_WIDTH  + 2*PADDING - KERNEL_SIZE) / STRIDE + 1;

    // Saturation bounds expressed at accumulator width so the compare is a plain signed compare.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_t;
    state_t state;

    int b_cnt, oc_cnt, oh_cnt, ow_cnt;
    int ic_cnt, kh_cnt, kw_cnt;
    logic signed [ACC_WIDTH-1:0] acc;

    int ih, iw, x_idx, w_idx;
    int nb, noc, noh, now, bias_oc;
    logic in_img, last_tap, last_out;
    logic signed [DATA_WIDTH-1:0]   x_op, w_op, bias_sel, sat_val, result;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_next, shifted, bias_acc;

    // Operand fetch for the current tap, accumulate, scale/saturate, next-output counters and bias.
    always_comb begin
        ih     = oh_cnt*STRIDE + kh_cnt - PADDING;
        iw     = ow_cnt*STRIDE + kw_cnt - PADDING;
        in_img = (ih >= 0) && (ih < IN_HEIGHT) && (iw >= 0) && (iw < IN_WIDTH);
        x_idx  = in_img ? (((b_cnt*IN_CHANNELS + ic_cnt)*IN_HEIGHT + ih)*IN_WIDTH + iw) : 0;
        w_idx  = ((oc_cnt*IN_CHANNELS + ic_cnt)*KERNEL_SIZE + kh_cnt)*KERNEL_SIZE + kw_cnt;
        // Padding taps contribute a zero operand rather than reading the bus.
        x_op   = in_img ? DATA_WIDTH'(input_tensor_flat >> (x_idx*DATA_WIDTH)) : '0;
        w_op   = DATA_WIDTH'(weights_flat >> (w_idx*DATA_WIDTH));
        prod     = x_op * w_op;
        acc_next = acc + ACC_WIDTH'(prod);
        shifted  = acc_next >>> FRAC_BITS;
        if (shifted > SAT_MAX)
            sat_val = DATA_WIDTH'(SAT_MAX);
        else if (shifted < SAT_MIN)
            sat_val = DATA_WIDTH'(SAT_MIN);
        else
            sat_val = DATA_WIDTH'(shifted);
`ifdef CONV2D_SEQ_RELU_EN
        result = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
        result = sat_val;
`endif
        last_tap = (ic_cnt == IN_CHANNELS-1) && (kh_cnt == KERNEL_SIZE-1) && (kw_cnt == KERNEL_SIZE-1);
        last_out = (b_cnt == BATCH_SIZE-1) && (oc_cnt == OUT_CHANNELS-1) &&
                   (oh_cnt == OUT_HEIGHT-1) && (ow_cnt == OUT_WIDTH-1);
        // Output order: ow fastest, then oh, oc, b.
        nb  = b_cnt;
        noc = oc_cnt;
        noh = oh_cnt;
        now = ow_cnt + 1;
        if (now == OUT_WIDTH) begin
            now = 0;
            noh = oh_cnt + 1;
            if (noh == OUT_HEIGHT) begin
                noh = 0;
                noc = oc_cnt + 1;
                if (noc == OUT_CHANNELS) begin
                    noc = 0;
                    nb  = b_cnt + 1;
                end
            end
        end
        bias_oc  = (state == IDLE) ? 0 : noc;
        bias_sel = DATA_WIDTH'(bias_flat >> (bias_oc*DATA_WIDTH));
        bias_acc = ACC_WIDTH'(bias_sel) <<< FRAC_BITS;
    end

    // Control FSM with registered outputs, counters and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            acc       <= '0;
            b_cnt     <= 0;
            oc_cnt    <= 0;
            oh_cnt    <= 0;
            ow_cnt    <= 0;
            ic_cnt    <= 0;
            kh_cnt    <= 0;
            kw_cnt    <= 0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= MAC;
                        busy      <= 1'b1;
                        out_index <= '0;
                        b_cnt     <= 0;
                        oc_cnt    <= 0;
                        oh_cnt    <= 0;
                        ow_cnt    <= 0;
                        ic_cnt    <= 0;
                        kh_cnt    <= 0;
                        kw_cnt    <= 0;
                        acc       <= bias_acc;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (last_tap) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_data  <= result;
                        ic_cnt    <= 0;
                        kh_cnt    <= 0;
                        kw_cnt    <= 0;
                    end else if (kw_cnt == KERNEL_SIZE-1) begin
                        kw_cnt <= 0;
                        if (kh_cnt == KERNEL_SIZE-1) begin
                            kh_cnt <= 0;
                            ic_cnt <= ic_cnt + 1;
                        end else begin
                            kh_cnt <= kh_cnt + 1;
                        end
                    end else begin
                        kw_cnt <= kw_cnt + 1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_out) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= MAC;
                            b_cnt     <= nb;
                            oc_cnt    <= noc;
                            oh_cnt    <= noh;
                            ow_cnt    <= now;
                            out_index <= out_index + 32'd1;
                            acc       <= bias_acc;
                        end
                    end
                end
                default: begin
                    // DONE: one-cycle pulse; a start seen here is deliberately dropped.
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_seq_engine.sv
module tb_conv2d_seq_engine;

    // Main instance: odd shapes, batch 2, stride 2, padding 1, fixed point with 2 fraction bits.
    localparam int DW = 8, FB = 2, BS = 2, IC = 2, OC = 2, IH = 5, IW = 4, K = 3, S = 2, P = 1;
    localparam int OH = (IH + 2*P - K)/S + 1;
    localparam int OW = (IW + 2*P - K)/S + 1;
    localparam int NOUT = BS*OC*OH*OW;
    localparam int NX = BS*IC*IH*IW;
    localparam int NW = OC*IC*K*K;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic              start_a = 0, ready_a = 0;
    logic [NX*DW-1:0]  in_a;
    logic [NW*DW-1:0]  w_a;
    logic [OC*DW-1:0]  b_a;
    logic              busy_a, valid_a, done_a;
    logic [DW-1:0]     data_a;
    logic [31:0]       index_a;

    conv2d_seq_engine #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .ACC_WIDTH(24), .BATCH_SIZE(BS),
        .IN_CHANNELS(IC), .OUT_CHANNELS(OC), .IN_HEIGHT(IH), .IN_WIDTH(IW),
        .KERNEL_SIZE(K), .STRIDE(S), .PADDING(P)) u_main (
        .clk(clk), .rst(rst), .start(start_a), .input_tensor_flat(in_a), .weights_flat(w_a),
        .bias_flat(b_a), .busy(busy_a), .out_valid(valid_a), .out_ready(ready_a),
        .out_data(data_a), .out_index(index_a), .done(done_a));

    // Second instance: 3x3 all-ones layer with known literal answers and exact timing.
    logic          start_b = 0, ready_b = 1;
    logic [143:0]  in_b, w_b;
    logic [15:0]   b_b;
    logic          busy_b, valid_b, done_b;
    logic [15:0]   data_b;
    logic [31:0]   index_b;

    conv2d_seq_engine #(.DATA_WIDTH(16), .FRAC_BITS(0), .ACC_WIDTH(32), .BATCH_SIZE(1),
        .IN_CHANNELS(1), .OUT_CHANNELS(1), .IN_HEIGHT(3), .IN_WIDTH(3),
        .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1)) u_small (
        .clk(clk), .rst(rst), .start(start_b), .input_tensor_flat(in_b), .weights_flat(w_b),
        .bias_flat(b_b), .busy(busy_b), .out_valid(valid_b), .out_ready(ready_b),
        .out_data(data_b), .out_index(index_b), .done(done_b));

    int xa[NX];
    int wa[NW];
    int ba[OC];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack_main();
        logic [31:0] v;
        for (int i = 0; i < NX; i++) begin v = xa[i]; in_a[i*DW +: DW] = v[DW-1:0]; end
        for (int i = 0; i < NW; i++) begin v = wa[i]; w_a[i*DW +: DW] = v[DW-1:0]; end
        for (int i = 0; i < OC; i++) begin v = ba[i]; b_a[i*DW +: DW] = v[DW-1:0]; end
    endtask

    task automatic rand_main();
        for (int i = 0; i < NX; i++) xa[i] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < NW; i++) wa[i] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < OC; i++) ba[i] = int'($urandom_range(0, 255)) - 128;
        pack_main();
    endtask

    // Reference: textbook convolution of one flat output index in real-number terms, then scale/clip.
    function automatic logic [DW-1:0] model(input int idx);
        int ow, oh, oc, b, ih, iw;
        longint acc, r;
        ow = idx % OW;
        oh = (idx / OW) % OH;
        oc = (idx / (OW*OH)) % OC;
        b  = idx / (OW*OH*OC);
        acc = longint'(ba[oc]) * (64'sd1 << FB);
        for (int c = 0; c < IC; c++)
            for (int kh = 0; kh < K; kh++)
                for (int kw = 0; kw < K; kw++) begin
                    ih = oh*S + kh - P;
                    iw = ow*S + kw - P;
                    if (ih >= 0 && ih < IH && iw >= 0 && iw < IW)
                        acc += longint'(xa[((b*IC + c)*IH + ih)*IW + iw]) *
                               longint'(wa[((oc*IC + c)*K + kh)*K + kw]);
                end
        r = acc >>> FB;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
`ifdef CONV2D_SEQ_RELU_EN
        if (r < 0) r = 0;
`endif
        return DW'(r);
    endfunction

    // Run one job on the main instance with random or scripted backpressure and score every output.
    task automatic run_job(input string name, input int ready_pct, input bit hold5, input bit poke);
        int got = 0, cyc = 0, holdcnt = 0, k = 0;
        bit stall = 0, rdy;
        logic [DW-1:0] pd = '0;
        logic [31:0] pi = '0;
        @(negedge clk); start_a = 1;
        @(negedge clk); start_a = 0;
        chk({name, "/busy_after_start"}, busy_a, 1);
        while (got < NOUT && cyc < 5000) begin
            if (stall) chk({name, "/frozen"}, {valid_a, index_a, data_a}, {1'b1, pi, pd});
            if (valid_a) begin
                if (hold5 && holdcnt < 5) begin rdy = 0; holdcnt++; end
                else rdy = ($urandom_range(0, 99) < ready_pct);
                if (rdy) begin
                    chk({name, "/index"}, index_a, got);
                    chk({name, "/data"}, data_a, model(got));
                    got++;
                end
                stall = !rdy;
                pd = data_a;
                pi = index_a;
            end else begin
                rdy = $urandom_range(0, 1) == 1;
                stall = 0;
            end
            ready_a = rdy;
            start_a = (poke && cyc == 30);
            @(negedge clk);
            cyc++;
        end
        start_a = 0;
        chk({name, "/outputs"}, got, NOUT);
        while (!done_a && k < 5) begin @(negedge clk); k++; end
        chk({name, "/done_busy"}, {done_a, busy_a}, 2'b10);
        @(negedge clk);
        chk({name, "/done_pulse"}, {done_a, busy_a}, 2'b00);
        ready_a = 0;
    endtask

    initial begin
        int t, g, last, k;
        int exp9[9] = '{4, 6, 4, 6, 9, 6, 4, 6, 4};

        in_a = '0; w_a = '0; b_a = '0;
        in_b = '0; w_b = '0; b_b = '0;
        #22;
        chk("reset_main", {busy_a, valid_a, done_a, data_a, index_a}, '0);
        chk("reset_small", {busy_b, valid_b, done_b, data_b, index_b}, '0);
        @(negedge clk); rst = 0;

        // 3x3 all-ones: literal sequence, 10-cycle spacing, 91-cycle job.
        for (int i = 0; i < 9; i++) begin in_b[i*16 +: 16] = 16'd1; w_b[i*16 +: 16] = 16'd1; end
        @(negedge clk); start_b = 1;
        t = 0; g = 0; last = 0;
        @(negedge clk); start_b = 0; t = 1;
        while (!done_b && t < 200) begin
            if (valid_b) begin
                if (g < 9) begin
                    chk("ones/data", data_b, exp9[g]);
                    chk("ones/index", index_b, g);
                end
                chk("ones/spacing", t - last, 10);
                last = t;
                g++;
            end
            @(negedge clk); t++;
        end
        chk("ones/count", g, 9);
        chk("ones/job_len", t, 91);
        chk("ones/done_busy", {done_b, busy_b}, 2'b10);
        @(negedge clk);
        chk("ones/done_pulse", {done_b, busy_b}, 2'b00);

        // Random jobs, varied backpressure, a stray start while busy, and a scripted 5-cycle stall.
        rand_main(); run_job("rand_full", 100, 0, 0);
        rand_main(); run_job("rand_half", 50, 0, 1);
        rand_main(); run_job("hold5", 100, 1, 0);
        rand_main(); run_job("rand_sparse", 25, 0, 1);

        // Saturation corners: large positive and large negative sums.
        foreach (xa[i]) xa[i] = 127;
        foreach (wa[i]) wa[i] = 127;
        foreach (ba[i]) ba[i] = 0;
        pack_main(); run_job("sat_pos", 100, 0, 0);
        foreach (wa[i]) wa[i] = -127;
        pack_main(); run_job("sat_neg", 70, 0, 0);

        // Mid-job reset during the MAC phase of output 3, then a clean rerun.
        rand_main();
        ready_a = 1;
        @(negedge clk); start_a = 1;
        @(negedge clk); start_a = 0;
        k = 0;
        while (!(index_a == 3 && !valid_a) && k < 2000) begin @(negedge clk); k++; end
        chk("midreset/reached", index_a, 3);
        repeat (4) @(negedge clk);
        rst = 1;
        #1;
        chk("midreset/outputs", {valid_a, busy_a, done_a, index_a}, '0);
        @(negedge clk); rst = 0;
        ready_a = 0;
        run_job("after_reset", 100, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
